// File: rtl/bw_io_ddr_dqs_gen_pkg.sv
// ---------------------------------------------------------------------------
// bw_io_ddr_dqs_gen_pkg
// Shared definitions for the DQS write-strobe generator:
//   dqsState_t    - FSM state encoding (IDLE, PRE, BURST, POST)
//   CNT_W         - width of the timed-state cycle counter
//   DEF_PRE_CYC   - default preamble length in clk cycles
//   DEF_POST_CYC  - default postamble length in clk cycles
//   burstLoad()   - counter load value for a burst of (len+1) DQS periods
// ---------------------------------------------------------------------------
package bw_io_ddr_dqs_gen_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        PRE   = 2'd1,
        BURST = 2'd2,
        POST  = 2'd3
    } dqsState_t;

    localparam int CNT_W        = 4;
    localparam int DEF_PRE_CYC  = 2;
    localparam int DEF_POST_CYC = 1;

    // A burst lasts 2*(len+1) cycles and the counter exits at zero, so the
    // load value is 2*len+1, which is simply len with a 1 appended.
    function automatic logic [CNT_W-1:0] burstLoad(input logic [2:0] len);
        return {len, 1'b1};
    endfunction

endpackage

// File: rtl/bw_io_ddr_dqs_gen_if.sv
// ---------------------------------------------------------------------------
// bw_io_ddr_dqs_gen_if
// Request/strobe bundle between a write-burst requester and the DQS
// generator.
//   wr_req    - write-burst request, held until wr_ack
//   wr_len    - burst length minus one, in DQS periods
//   wr_ack    - one-cycle combinational acceptance of wr_req
//   strobe    - functional DQS level
//   strobe_oe - DQS pad output-enable
//   dq_valid  - a data beat is launched this cycle
//   busy      - generator is not idle
// master: the requester side; slave: the generator side.
// ---------------------------------------------------------------------------
interface bw_io_ddr_dqs_gen_if;

    logic       wr_req;
    logic [2:0] wr_len;
    logic       wr_ack;
    logic       strobe;
    logic       strobe_oe;
    logic       dq_valid;
    logic       busy;

    modport master (
        output wr_req,
        output wr_len,
        input  wr_ack,
        input  strobe,
        input  strobe_oe,
        input  dq_valid,
        input  busy
    );

    modport slave (
        input  wr_req,
        input  wr_len,
        output wr_ack,
        output strobe,
        output strobe_oe,
        output dq_valid,
        output busy
    );

endinterface

// File: rtl/bw_io_ddr_dqs_gen_cnt.sv
// ---------------------------------------------------------------------------
// bw_io_ddr_dqs_cnt
// Loadable down-counter with a zero flag that times the PRE, BURST and
// POST states of the DQS generator.
//   clk        - block clock
//   rst        - synchronous active-high reset, clears the count
//   i_load     - load i_loadVal this cycle (has priority over i_dec)
//   i_loadVal  - value to load
//   i_dec      - decrement this cycle; holds at zero instead of wrapping
//   o_zero     - count is zero
// ---------------------------------------------------------------------------
module bw_io_ddr_dqs_cnt
    import bw_io_ddr_dqs_gen_pkg::*;
(
    input  logic             clk,
    input  logic             rst,
    input  logic             i_load,
    input  logic [CNT_W-1:0] i_loadVal,
    input  logic             i_dec,
    output logic             o_zero
);

    logic [CNT_W-1:0] r_count;

    // Load wins over decrement; a decrement at zero is ignored so the
    // counter can never wrap back to its maximum value.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_count <= '0;
        end else if (i_load) begin
            r_count <= i_loadVal;
        end else if (i_dec && (r_count != '0)) begin
            r_count <= r_count - CNT_W'(1);
        end
    end

    assign o_zero = (r_count == '0);

endmodule

// File: rtl/bw_io_ddr_dqs_gen.sv
// ---------------------------------------------------------------------------
// bw_io_ddr_dqs_gen
// DQS write-strobe generator. Each accepted write burst produces a
// preamble (strobe low, driver enabled), a toggling strobe burst of
// 2*(wr_len+1) cycles with dq_valid high, and a postamble. A request
// accepted on the last burst cycle continues seamlessly into a new burst.
//   clk        - block clock
//   rst        - synchronous active-high reset
//   io_bus     - slave side of bw_io_ddr_dqs_gen_if (wr_req, wr_len in;
//                wr_ack, strobe, strobe_oe, dq_valid, busy out)
// Parameters:
//   PRE_CYC    - preamble length in clk cycles (1..3)
//   POST_CYC   - postamble length in clk cycles (1..3)
// ---------------------------------------------------------------------------
module bw_io_ddr_dqs_gen
    import bw_io_ddr_dqs_gen_pkg::*;
#(
    parameter int PRE_CYC  = DEF_PRE_CYC,
    parameter int POST_CYC = DEF_POST_CYC
)
(
    input  logic                      clk,
    input  logic                      rst,
    bw_io_ddr_dqs_gen_if.slave        io_bus
);

    localparam logic [CNT_W-1:0] PRE_LOAD  = CNT_W'(PRE_CYC - 1);
    localparam logic [CNT_W-1:0] POST_LOAD = CNT_W'(POST_CYC - 1);

    dqsState_t        r_state;
    dqsState_t        w_nextState;
    logic [2:0]       r_len;
    logic [2:0]       w_nextLen;
    logic             r_strobe;
    logic             r_strobeOe;
    logic             r_dqValid;
    logic             r_busy;
    logic             w_nextStrobe;
    logic             w_nextStrobeOe;
    logic             w_nextDqValid;
    logic             w_nextBusy;
    logic             w_lastBurst;
    logic             w_accept;
    logic             w_cntLoad;
    logic [CNT_W-1:0] w_cntLoadVal;
    logic             w_cntDec;
    logic             w_cntZero;

    bw_io_ddr_dqs_cnt u_cnt (
        .clk       (clk),
        .rst       (rst),
        .i_load    (w_cntLoad),
        .i_loadVal (w_cntLoadVal),
        .i_dec     (w_cntDec),
        .o_zero    (w_cntZero)
    );

    // A request is taken only from IDLE or on the final burst cycle, and
    // never while reset is held.
    always_comb begin
        w_lastBurst = (r_state == BURST) && w_cntZero;
        w_accept    = !rst && io_bus.wr_req && ((r_state == IDLE) || w_lastBurst);
    end

    // Next-state, counter control and next output values. Outputs are
    // derived from the next state so the flops below present them in the
    // same cycle the state becomes current.
    always_comb begin
        w_nextState  = r_state;
        w_nextLen    = r_len;
        w_nextStrobe = 1'b0;
        w_cntLoad    = 1'b0;
        w_cntLoadVal = '0;
        w_cntDec     = 1'b0;
        case (r_state)
            IDLE: begin
                if (w_accept) begin
                    w_nextState  = PRE;
                    w_nextLen    = io_bus.wr_len;
                    w_cntLoad    = 1'b1;
                    w_cntLoadVal = PRE_LOAD;
                end
            end
            PRE: begin
                if (w_cntZero) begin
                    w_nextState  = BURST;
                    w_nextStrobe = 1'b1;
                    w_cntLoad    = 1'b1;
                    w_cntLoadVal = burstLoad(r_len);
                end else begin
                    w_cntDec = 1'b1;
                end
            end
            BURST: begin
                if (w_cntZero) begin
                    if (w_accept) begin
                        w_nextState  = BURST;
                        w_nextLen    = io_bus.wr_len;
                        w_nextStrobe = 1'b1;
                        w_cntLoad    = 1'b1;
                        w_cntLoadVal = burstLoad(io_bus.wr_len);
                    end else begin
                        w_nextState  = POST;
                        w_cntLoad    = 1'b1;
                        w_cntLoadVal = POST_LOAD;
                    end
                end else begin
                    w_nextStrobe = ~r_strobe;
                    w_cntDec     = 1'b1;
                end
            end
            POST: begin
                if (w_cntZero) begin
                    w_nextState = IDLE;
                end else begin
                    w_cntDec = 1'b1;
                end
            end
            default: begin
                w_nextState = IDLE;
            end
        endcase
        w_nextStrobeOe = (w_nextState != IDLE);
        w_nextDqValid  = (w_nextState == BURST);
        w_nextBusy     = (w_nextState != IDLE);
    end

    // State, captured length and registered outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= IDLE;
            r_len      <= '0;
            r_strobe   <= 1'b0;
            r_strobeOe <= 1'b0;
            r_dqValid  <= 1'b0;
            r_busy     <= 1'b0;
        end else begin
            r_state    <= w_nextState;
            r_len      <= w_nextLen;
            r_strobe   <= w_nextStrobe;
            r_strobeOe <= w_nextStrobeOe;
            r_dqValid  <= w_nextDqValid;
            r_busy     <= w_nextBusy;
        end
    end

    assign io_bus.wr_ack    = w_accept;
    assign io_bus.strobe    = r_strobe;
    assign io_bus.strobe_oe = r_strobeOe;
    assign io_bus.dq_valid  = r_dqValid;
    assign io_bus.busy      = r_busy;

endmodule

// File: doc/bw_io_ddr_dqs_gen.md
BW_IO_DDR_DQS_GEN -- requirements
Module: bw_io_ddr_dqs_gen

Interface
REQ-001 Parameter PRE_CYC, default 2, preamble length in clk cycles (legal 1..3).
REQ-002 Parameter POST_CYC, default 1, postamble length in clk cycles (legal 1..3).
REQ-003 clk  input  1  single block clock; all state changes on its rising edge.
REQ-004 rst  input  1  reset, synchronous and active-high.
REQ-005 wr_req  input  1  write-burst request, held until wr_ack.
REQ-006 wr_len  input  3  burst length minus one, in DQS periods (0 = 1 period, 7 = 8 periods).
REQ-007 wr_ack  output  1  combinational one-cycle acceptance of wr_req.
REQ-008 strobe  output  1  registered functional DQS level; feeds the strobe input of the downstream DDR test mux.
REQ-009 strobe_oe  output  1  registered pad output-enable for the DQS driver.
REQ-010 dq_valid  output  1  registered; high during every cycle in which a data beat is launched.
REQ-011 busy  output  1  registered; high whenever the state is not IDLE.

Function
REQ-012 FSM states: IDLE, PRE, BURST, POST.
REQ-013 Acceptance: wr_ack = wr_req AND (state==IDLE OR (state==BURST AND last burst cycle)); wr_len is captured only on acceptance.
REQ-014 IDLE: strobe=0, strobe_oe=0, dq_valid=0; on acceptance, go to PRE next cycle.
REQ-015 PRE: exactly PRE_CYC cycles; strobe=0, strobe_oe=1, dq_valid=0; then go to BURST.
REQ-016 BURST: exactly 2*(wr_len+1) cycles; strobe_oe=1, dq_valid=1; strobe=1 on the first cycle and toggles every cycle after (1,0,1,0,...), so the last burst cycle has strobe=0.
REQ-017 Last BURST cycle with acceptance: seamless continuation; go directly to BURST with the new length, no PRE and no POST, strobe=1 on the next cycle.
REQ-018 Last BURST cycle without acceptance: go to POST.
REQ-019 POST: exactly POST_CYC cycles; strobe=0, strobe_oe=1, dq_valid=0; then go to IDLE.
REQ-020 wr_req in PRE, in POST, or in a non-last BURST cycle is not acknowledged; it is accepted once the block reaches IDLE or the last BURST cycle.
REQ-021 Latency: from acceptance cycle T, strobe_oe rises at T+1 and the first strobe=1 occurs at T+1+PRE_CYC.
REQ-022 Cycle counter: 4 bits, loaded on entry to each timed state, decremented each cycle; a state exits at count 0; no wrap-around is permitted.
REQ-023 strobe, strobe_oe and dq_valid are direct flop outputs with no combinational path from inputs; wr_ack is the only combinational output.

Reset
REQ-024 While rst=1 at a clk edge: state=IDLE, counter=0, captured length=0, strobe=0, strobe_oe=0, dq_valid=0, busy=0.
REQ-025 wr_ack is forced to 0 while rst=1.
REQ-026 Reset asserted mid-burst aborts the burst on the next edge with no postamble; the first request after reset release is handled as if from IDLE.

Structure
REQ-027 A shared package holds the state enum, the counter width (4), and the default PRE_CYC and POST_CYC values.
REQ-028 One natural sub-module: bw_io_ddr_dqs_cnt, a loadable down-counter with a zero flag, instantiated once.
REQ-029 Flops use synchronous reset only; no latches; no clock gating; single clock domain.

Verification
REQ-030 Reset, then wr_req=1, wr_len=0 at cycle 0 -> wr_ack=1 at cycle 0; oe high cycles 1-5; strobe 0,0,1,0,0 over cycles 1-5; dq_valid high cycles 3-4; IDLE at cycle 6.
REQ-031 wr_len=7 single burst -> 16 BURST cycles; strobe alternates starting at 1; dq_valid high for exactly 16 cycles.
REQ-032 Second wr_req held high during the first burst (wr_len=1) -> wr_ack on the last BURST cycle; next cycle strobe=1; no PRE or POST cycles between the bursts; 8 contiguous dq_valid cycles.
REQ-033 wr_req raised during POST -> no wr_ack until IDLE; the new burst then starts with a full PRE.
REQ-034 rst=1 on the 3rd BURST cycle -> next cycle all outputs 0 and busy=0; a request after release is accepted normally.
REQ-035 PRE_CYC=3, POST_CYC=3 build, wr_len=2 -> oe high for exactly 12 cycles: 3 PRE, 6 BURST, 3 POST.
